multicycle_control: RTL and testbench

//  Multi-cycle successor of the single-cycle MIPS main decoder: an FSM that sequences

---
 rtl/multicycle_control_pkg.sv | 77 +++++++
 rtl/multicycle_control_if.sv | 52 +++++
 rtl/multicycle_control.sv | 255 +++++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_pkg.sv
// ----------------------------------------------------------------------------
// multicycle_control_pkg
//   Shared definitions for the multi-cycle MIPS main controller:
//   - opcode constants (IR[31:26])
//   - ALU operation, ALU B-source and PC-source encodings
//   - FSM state encoding
//   - decode_next(): DECODE dispatch from opcode to the first execute state.
//     Unsupported opcodes return S_FETCH; the controller uses this as its
//     illegal-opcode indication.
// ----------------------------------------------------------------------------
package multicycle_control_pkg;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // ALU operation encodings
  localparam logic [3:0] ALUOP_ADD   = 4'b0000;
  localparam logic [3:0] ALUOP_SUB   = 4'b0001;
  localparam logic [3:0] ALUOP_FUNCT = 4'b0111;
  localparam logic [3:0] ALUOP_LUI   = 4'b1000;
  localparam logic [3:0] ALUOP_OR    = 4'b1001;

  // ALU B-input select
  localparam logic [1:0] ALUSRCB_RT    = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
  localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_ADDIEX = 4'd8,
    S_LUIEX  = 4'd9,
    S_ORIEX  = 4'd10,
    S_IMMWB  = 4'd11,
    S_BRANCH = 4'd12,
    S_JUMP   = 4'd13,
    S_JAL    = 4'd14
  } state_e;

  function automatic state_e decode_next(input logic [5:0] op);
    state_e nxt;
    case (op)
      OP_LW, OP_SW:   nxt = S_MEMADR;
      OP_RTYPE:       nxt = S_EXEC;
      OP_BEQ, OP_BNE: nxt = S_BRANCH;
      OP_ADDI:        nxt = S_ADDIEX;
      OP_LUI:         nxt = S_LUIEX;
      OP_ORI:         nxt = S_ORIEX;
      OP_J:           nxt = S_JUMP;
      OP_JAL:         nxt = S_JAL;
      default:        nxt = S_FETCH;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// ----------------------------------------------------------------------------
// multicycle_control_if
//   Bundle between the multi-cycle controller and the datapath / memory.
//   master : the controller (takes opcode and mem_ready, drives every enable)
//   slave  : the datapath side (drives opcode and mem_ready, takes enables)
//   Signals:
//     opcode       IR[31:26]
//     mem_ready    memory finished the current access this cycle
//     pcwrite, pcwritecond, bne, pcsrc   PC update control
//     iord, memread, memwrite, irwrite   memory / IR control
//     memtoreg, regdst, regwrite, link   register file write control
//     alusrca, alusrcb, aluop            ALU operand / operation select
//     instr_done, illegal_op, mem_timeout  status
// ----------------------------------------------------------------------------
interface multicycle_control_if #(
  parameter int ALUOP_W = 4
);
  logic [5:0]         opcode;
  logic               mem_ready;
  logic               pcwrite;
  logic               pcwritecond;
  logic               bne;
  logic               iord;
  logic               memread;
  logic               memwrite;
  logic               irwrite;
  logic               memtoreg;
  logic               regdst;
  logic               regwrite;
  logic               link;
  logic               alusrca;
  logic [1:0]         alusrcb;
  logic [ALUOP_W-1:0] aluop;
  logic [1:0]         pcsrc;
  logic               instr_done;
  logic               illegal_op;
  logic               mem_timeout;

  modport master (
    input  opcode, mem_ready,
    output pcwrite, pcwritecond, bne, iord, memread, memwrite, irwrite,
           memtoreg, regdst, regwrite, link, alusrca, alusrcb, aluop, pcsrc,
           instr_done, illegal_op, mem_timeout
  );

  modport slave (
    output opcode, mem_ready,
    input  pcwrite, pcwritecond, bne, iord, memread, memwrite, irwrite,
           memtoreg, regdst, regwrite, link, alusrca, alusrcb, aluop, pcsrc,
           instr_done, illegal_op, mem_timeout
  );
endinterface

// File: rtl/multicycle_control.sv
// ----------------------------------------------------------------------------
// multicycle_control
//   Multi-cycle MIPS main controller. Sequences FETCH/DECODE/EXEC/MEM/WB per
//   instruction and drives the shared datapath enables each cycle. Memory
//   states wait on mem_ready with a bounded wait; an overflow raises the
//   sticky mem_timeout and abandons the instruction. Unsupported opcodes
//   pulse illegal_op in DECODE and return to FETCH without any write.
//   Ports:
//     clk  rising-edge clock
//     rst  synchronous active-high reset
//     bus  controller side (master) of multicycle_control_if
//
//   state  | meaning
//   FETCH  | read instruction at PC, PC <= PC+4 on mem_ready
//   DECODE | ALUOut <= branch target, dispatch on opcode
//   MEMADR | ALUOut <= rs + sign-ext imm (lw/sw address)
//   MEMRD  | read data memory, wait for mem_ready
//   MEMWB  | rt <= MDR
//   MEMWR  | write data memory, wait for mem_ready
//   EXEC   | R-type ALU operation
//   ALUWB  | rd <= ALUOut
//   ADDIEX | rs + imm
//   LUIEX  | imm << 16
//   ORIEX  | rs | imm
//   IMMWB  | rt <= ALUOut
//   BRANCH | conditional PC <= ALUOut (beq/bne)
//   JUMP   | PC <= jump target
//   JAL    | PC <= jump target, $31 <= PC+4
// ----------------------------------------------------------------------------
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int ALUOP_W      = 4,
  parameter int MEM_WAIT_MAX = 15,
  parameter int WAIT_CNT_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  multicycle_control_if.master bus
);

  state_e                state_q, state_d;
  logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic                  tmo_q, tmo_d;
  logic                  bne_q, bne_d;
  logic                  is_sw_q, is_sw_d;
  // High for the cycle following any reset edge; keeps all enables low and
  // the FSM parked in FETCH so that state shows no activity right after rst.
  logic                  boot_q;

  state_e op_next;
  logic   mem_state;
  logic   wait_full;
  logic   timeout_now;
  logic   illegal_now;

  logic               pcwrite, pcwritecond, bne, iord, memread, memwrite;
  logic               irwrite, memtoreg, regdst, regwrite, link, alusrca;
  logic [1:0]         alusrcb, pcsrc;
  logic [ALUOP_W-1:0] aluop;
  logic               instr_done, illegal_op;

  assign op_next     = decode_next(bus.opcode);
  assign mem_state   = !boot_q &&
                       (state_q == S_FETCH || state_q == S_MEMRD || state_q == S_MEMWR);
  assign wait_full   = (wait_cnt_q == WAIT_CNT_W'(MEM_WAIT_MAX));
  // mem_ready in the overflow cycle wins over the timeout.
  assign timeout_now = mem_state && !bus.mem_ready && wait_full;
  assign illegal_now = (state_q == S_DECODE) && (op_next == S_FETCH);

  // State and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_FETCH;
      wait_cnt_q <= '0;
      tmo_q      <= 1'b0;
      bne_q      <= 1'b0;
      is_sw_q    <= 1'b0;
      boot_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      tmo_q      <= tmo_d;
      bne_q      <= bne_d;
      is_sw_q    <= is_sw_d;
      boot_q     <= 1'b0;
    end
  end

  // Next-state, wait counter and latched opcode flags
  always_comb begin
    state_d = state_q;
    bne_d   = bne_q;
    is_sw_d = is_sw_q;
    tmo_d   = tmo_q | timeout_now;

    if (boot_q) begin
      state_d = S_FETCH;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (bus.mem_ready)  state_d = S_DECODE;
        end
        S_DECODE: begin
          state_d = op_next;
          bne_d   = (bus.opcode == OP_BNE);
          is_sw_d = (bus.opcode == OP_SW);
        end
        S_MEMADR: state_d = is_sw_q ? S_MEMWR : S_MEMRD;
        S_MEMRD: begin
          if (bus.mem_ready)  state_d = S_MEMWB;
          else if (wait_full) state_d = S_FETCH;
        end
        S_MEMWR: begin
          if (bus.mem_ready || wait_full) state_d = S_FETCH;
        end
        S_EXEC:   state_d = S_ALUWB;
        S_ADDIEX: state_d = S_IMMWB;
        S_LUIEX:  state_d = S_IMMWB;
        S_ORIEX:  state_d = S_IMMWB;
        default:  state_d = S_FETCH;
      endcase
    end

    // Any state change (or a timeout, which re-enters FETCH) restarts the
    // count, so every memory wait begins from zero.
    if (boot_q || timeout_now || (state_d != state_q)) begin
      wait_cnt_d = '0;
    end else if (mem_state && !bus.mem_ready && !wait_full) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end else begin
      wait_cnt_d = wait_cnt_q;
    end
  end

  // Output decode
  always_comb begin
    pcwrite     = 1'b0;
    pcwritecond = 1'b0;
    bne         = 1'b0;
    iord        = 1'b0;
    memread     = 1'b0;
    memwrite    = 1'b0;
    irwrite     = 1'b0;
    memtoreg    = 1'b0;
    regdst      = 1'b0;
    regwrite    = 1'b0;
    link        = 1'b0;
    alusrca     = 1'b0;
    alusrcb     = ALUSRCB_RT;
    aluop       = ALUOP_W'(ALUOP_ADD);
    pcsrc       = PCSRC_ALU;
    instr_done  = 1'b0;
    illegal_op  = 1'b0;

    if (!boot_q) begin
      case (state_q)
        S_FETCH: begin
          memread = !timeout_now;
          alusrcb = ALUSRCB_FOUR;
          irwrite = bus.mem_ready;
          pcwrite = bus.mem_ready;
        end
        S_DECODE: begin
          alusrcb    = ALUSRCB_IMMSH;
          illegal_op = illegal_now;
          instr_done = illegal_now;
        end
        S_MEMADR: begin
          alusrca = 1'b1;
          alusrcb = ALUSRCB_IMM;
        end
        S_MEMRD: begin
          iord    = 1'b1;
          memread = !timeout_now;
        end
        S_MEMWB: begin
          regwrite   = 1'b1;
          memtoreg   = 1'b1;
          instr_done = 1'b1;
        end
        S_MEMWR: begin
          iord       = 1'b1;
          memwrite   = !timeout_now;
          instr_done = bus.mem_ready;
        end
        S_EXEC: begin
          alusrca = 1'b1;
          alusrcb = ALUSRCB_RT;
          aluop   = ALUOP_W'(ALUOP_FUNCT);
        end
        S_ALUWB: begin
          regwrite   = 1'b1;
          regdst     = 1'b1;
          instr_done = 1'b1;
        end
        S_ADDIEX, S_LUIEX, S_ORIEX: begin
          alusrca = 1'b1;
          alusrcb = ALUSRCB_IMM;
          if (state_q == S_LUIEX)      aluop = ALUOP_W'(ALUOP_LUI);
          else if (state_q == S_ORIEX) aluop = ALUOP_W'(ALUOP_OR);
          else                         aluop = ALUOP_W'(ALUOP_ADD);
        end
        S_IMMWB: begin
          regwrite   = 1'b1;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          alusrca     = 1'b1;
          alusrcb     = ALUSRCB_RT;
          aluop       = ALUOP_W'(ALUOP_SUB);
          pcwritecond = 1'b1;
          pcsrc       = PCSRC_ALUOUT;
          bne         = bne_q;
          instr_done  = 1'b1;
        end
        S_JUMP: begin
          pcwrite    = 1'b1;
          pcsrc      = PCSRC_JUMP;
          instr_done = 1'b1;
        end
        S_JAL: begin
          pcwrite    = 1'b1;
          pcsrc      = PCSRC_JUMP;
          regwrite   = 1'b1;
          link       = 1'b1;
          instr_done = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.pcwrite     = pcwrite;
  assign bus.pcwritecond = pcwritecond;
  assign bus.bne         = bne;
  assign bus.iord        = iord;
  assign bus.memread     = memread;
  assign bus.memwrite    = memwrite;
  assign bus.irwrite     = irwrite;
  assign bus.memtoreg    = memtoreg;
  assign bus.regdst      = regdst;
  assign bus.regwrite    = regwrite;
  assign bus.link        = link;
  assign bus.alusrca     = alusrca;
  assign bus.alusrcb     = alusrcb;
  assign bus.aluop       = aluop;
  assign bus.pcsrc       = pcsrc;
  assign bus.instr_done  = instr_done;
  assign bus.illegal_op  = illegal_op;
  // Visible in the overflow cycle itself, then held by the sticky register.
  assign bus.mem_timeout = tmo_q | timeout_now;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;
  import multicycle_control_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multicycle_control_if #(.ALUOP_W(4)) bus_if ();

  multicycle_control #(
    .ALUOP_W(4),
    .MEM_WAIT_MAX(15),
    .WAIT_CNT_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  typedef struct packed {
    logic       pcwrite, pcwritecond, bne, iord, memread, memwrite, irwrite;
    logic       memtoreg, regdst, regwrite, link, alusrca;
    logic [1:0] alusrcb;
    logic [3:0] aluop;
    logic [1:0] pcsrc;
    logic       instr_done, illegal_op, mem_timeout;
  } ctl_t;

  typedef enum {
    E_FETCH, E_DECODE, E_MEMADR, E_MEMRD, E_MEMWB, E_MEMWR, E_EXEC, E_ALUWB,
    E_ADDIEX, E_LUIEX, E_ORIEX, E_IMMWB, E_BRANCH, E_JUMP, E_JAL
  } tst_e;

  ctl_t       q_exp[$];
  logic       q_rdy[$];
  logic [5:0] q_op[$];
  string      q_tag[$];

  int   n_chk = 0;
  int   n_fail = 0;
  int   done_seen = 0;
  int   done_exp = 0;
  logic tmo_exp = 1'b0;

  always @(posedge clk) if (bus_if.instr_done === 1'b1) done_seen <= done_seen + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic ctl_t sample();
    ctl_t s;
    s.pcwrite     = bus_if.pcwrite;
    s.pcwritecond = bus_if.pcwritecond;
    s.bne         = bus_if.bne;
    s.iord        = bus_if.iord;
    s.memread     = bus_if.memread;
    s.memwrite    = bus_if.memwrite;
    s.irwrite     = bus_if.irwrite;
    s.memtoreg    = bus_if.memtoreg;
    s.regdst      = bus_if.regdst;
    s.regwrite    = bus_if.regwrite;
    s.link        = bus_if.link;
    s.alusrca     = bus_if.alusrca;
    s.alusrcb     = bus_if.alusrcb;
    s.aluop       = bus_if.aluop;
    s.pcsrc       = bus_if.pcsrc;
    s.instr_done  = bus_if.instr_done;
    s.illegal_op  = bus_if.illegal_op;
    s.mem_timeout = bus_if.mem_timeout;
    return s;
  endfunction

  function automatic logic is_legal(input logic [5:0] op);
    return op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101,
                      6'b001000, 6'b001111, 6'b001101, 6'b000010, 6'b000011};
  endfunction

  // Expected enables for one cycle of a state, from the control table.
  function automatic ctl_t exp_of(input tst_e st, input logic rdy, input logic [5:0] iop);
    ctl_t e;
    e = '0;
    case (st)
      E_FETCH:  begin e.memread = 1; e.alusrcb = 2'b01; e.irwrite = rdy; e.pcwrite = rdy; end
      E_DECODE: begin e.alusrcb = 2'b11; e.illegal_op = !is_legal(iop); e.instr_done = !is_legal(iop); end
      E_MEMADR: begin e.alusrca = 1; e.alusrcb = 2'b10; end
      E_MEMRD:  begin e.iord = 1; e.memread = 1; end
      E_MEMWB:  begin e.regwrite = 1; e.memtoreg = 1; e.instr_done = 1; end
      E_MEMWR:  begin e.iord = 1; e.memwrite = 1; e.instr_done = rdy; end
      E_EXEC:   begin e.alusrca = 1; e.aluop = 4'b0111; end
      E_ALUWB:  begin e.regwrite = 1; e.regdst = 1; e.instr_done = 1; end
      E_ADDIEX: begin e.alusrca = 1; e.alusrcb = 2'b10; e.aluop = 4'b0000; end
      E_LUIEX:  begin e.alusrca = 1; e.alusrcb = 2'b10; e.aluop = 4'b1000; end
      E_ORIEX:  begin e.alusrca = 1; e.alusrcb = 2'b10; e.aluop = 4'b1001; end
      E_IMMWB:  begin e.regwrite = 1; e.instr_done = 1; end
      E_BRANCH: begin
        e.alusrca = 1; e.aluop = 4'b0001; e.pcwritecond = 1; e.pcsrc = 2'b01;
        e.bne = (iop == 6'b000101); e.instr_done = 1;
      end
      E_JUMP:   begin e.pcwrite = 1; e.pcsrc = 2'b10; e.instr_done = 1; end
      E_JAL:    begin e.pcwrite = 1; e.pcsrc = 2'b10; e.regwrite = 1; e.link = 1; e.instr_done = 1; end
      default:  e = '0;
    endcase
    return e;
  endfunction

  task automatic push_raw(input ctl_t e, input logic rdy, input logic [5:0] sop, input string tag);
    e.mem_timeout = e.mem_timeout | tmo_exp;
    if (e.instr_done) done_exp++;
    q_exp.push_back(e);
    q_rdy.push_back(rdy);
    q_op.push_back(sop);
    q_tag.push_back(tag);
  endtask

  task automatic push(input tst_e st, input logic rdy, input logic [5:0] sop,
                      input logic [5:0] iop, input string tag);
    push_raw(exp_of(st, rdy, iop), rdy, sop, tag);
  endtask

  // Apply queued stimulus cycle by cycle and compare each cycle's outputs.
  task automatic drain();
    ctl_t  e;
    string tag;
    while (q_exp.size() > 0) begin
      e                = q_exp.pop_front();
      bus_if.mem_ready = q_rdy.pop_front();
      bus_if.opcode    = q_op.pop_front();
      tag              = q_tag.pop_front();
      @(negedge clk);
      chk(tag, {9'b0, sample()}, {9'b0, e});
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    bus_if.mem_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk({tag, "_outs"}, {9'b0, sample()}, 32'd0);
    chk({tag, "_tmo"}, {31'b0, bus_if.mem_timeout}, 32'd0);
    tmo_exp = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // Queue one instruction: wf FETCH stall cycles, wm memory stall cycles;
  // abort stops the queue inside the MEMRD wait.
  task automatic run_instr(input logic [5:0] op, input int wf, input int wm, input bit abort);
    logic [5:0] junk;
    int         cnt;
    ctl_t       e;
    junk = op ^ 6'b000001;
    cnt  = 0;
    for (int i = 0; i < wf; i++) begin
      if (cnt == 15) begin
        tmo_exp = 1'b1;
        e = exp_of(E_FETCH, 1'b0, op);
        e.memread = 1'b0;
        push_raw(e, 1'b0, op, "fetch_timeout");
        cnt = 0;
      end else begin
        push(E_FETCH, 1'b0, op, op, "fetch_wait");
        cnt++;
      end
    end
    push(E_FETCH, 1'b1, op, op, "fetch");
    push(E_DECODE, 1'($urandom_range(0, 1)), op, op, "decode");
    case (op)
      OP_LW: begin
        push(E_MEMADR, 1'($urandom_range(0, 1)), junk, op, "lw_memadr");
        for (int i = 0; i < wm; i++) push(E_MEMRD, 1'b0, junk, op, "lw_memrd_wait");
        if (!abort) begin
          push(E_MEMRD, 1'b1, junk, op, "lw_memrd");
          push(E_MEMWB, 1'($urandom_range(0, 1)), junk, op, "lw_memwb");
        end
      end
      OP_SW: begin
        push(E_MEMADR, 1'($urandom_range(0, 1)), junk, op, "sw_memadr");
        for (int i = 0; i < wm; i++) push(E_MEMWR, 1'b0, junk, op, "sw_memwr_wait");
        push(E_MEMWR, 1'b1, junk, op, "sw_memwr");
      end
      OP_RTYPE: begin
        push(E_EXEC, 1'b1, junk, op, "r_exec");
        push(E_ALUWB, 1'b0, junk, op, "r_aluwb");
      end
      OP_ADDI: begin
        push(E_ADDIEX, 1'b0, junk, op, "addi_ex");
        push(E_IMMWB, 1'b1, junk, op, "addi_wb");
      end
      OP_LUI: begin
        push(E_LUIEX, 1'b1, junk, op, "lui_ex");
        push(E_IMMWB, 1'b0, junk, op, "lui_wb");
      end
      OP_ORI: begin
        push(E_ORIEX, 1'b0, junk, op, "ori_ex");
        push(E_IMMWB, 1'b0, junk, op, "ori_wb");
      end
      OP_BEQ, OP_BNE: push(E_BRANCH, 1'($urandom_range(0, 1)), junk, op, "branch");
      OP_J:           push(E_JUMP, 1'b1, junk, op, "jump");
      OP_JAL:         push(E_JAL, 1'b0, junk, op, "jal");
      default: begin
      end
    endcase
    drain();
  endtask

  initial begin
    rst = 1'b1;
    bus_if.opcode = 6'b000000;
    bus_if.mem_ready = 1'b0;

    do_reset("rst_init");

    run_instr(OP_LW,    0, 0, 1'b0);
    run_instr(OP_LW,    2, 3, 1'b0);
    run_instr(OP_SW,    0, 3, 1'b0);
    run_instr(OP_SW,    1, 0, 1'b0);
    run_instr(OP_RTYPE, 0, 0, 1'b0);
    run_instr(OP_ADDI,  0, 0, 1'b0);
    run_instr(OP_LUI,   0, 0, 1'b0);
    run_instr(OP_ORI,   0, 0, 1'b0);
    run_instr(OP_BNE,   0, 0, 1'b0);
    run_instr(OP_BEQ,   0, 0, 1'b0);
    run_instr(OP_J,     0, 0, 1'b0);
    run_instr(6'b111111, 0, 0, 1'b0);

    // Reset while lw waits in MEMRD
    run_instr(OP_LW, 0, 2, 1'b1);
    do_reset("rst_mid_memrd");

    // 20-cycle FETCH stall: timeout in stall cycle 16, then jal completes
    run_instr(OP_JAL, 20, 0, 1'b0);
    @(negedge clk);
    chk("tmo_sticky", {31'b0, bus_if.mem_timeout}, 32'd1);
    @(posedge clk); #1;

    chk("done_count", 32'(done_seen), 32'(done_exp));

    do_reset("rst_final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
